// File: rtl/serial_cmd_router_if.sv
// Bundle of the byte-stream, status and downstream-channel signals of serial_cmd_router.
// master: host side (RX FIFO, FT2 write path, channel engines); slave: the router itself.
interface serial_cmd_router_if #(
  parameter int NUM_CH = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [NUM_CH-1:0] ch_sel;
  logic              ch_start;
  logic [7:0]        ch_data;
  logic              ch_valid;
  logic              ch_ready;
  logic [NUM_CH-1:0] ch_done;
  logic              busy;
  logic [7:0]        err_count;

  modport master (
    output in_data, in_valid, out_ready, ch_ready, ch_done,
    input  in_ready, out_data, out_valid, ch_sel, ch_start, ch_data, ch_valid, busy, err_count
  );

  modport slave (
    input  in_data, in_valid, out_ready, ch_ready, ch_done,
    output in_ready, out_data, out_valid, ch_sel, ch_start, ch_data, ch_valid, busy, err_count
  );
endinterface

// File: rtl/serial_cmd_router.sv
// Length-prefixed command packet parser: HDR {SYNC, ch}, LEN, LEN payload bytes.
// Payload is forwarded to the selected channel; one status byte is returned per packet.
module serial_cmd_router #(
  parameter int         NUM_CH  = 8,
  parameter logic [3:0] SYNC    = 4'hF,
  parameter int         TIMEOUT = 1000000,
  parameter int         TO_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_cmd_router_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_DONE, S_STATUS} state_t;

  localparam logic [7:0] CODE_HDR = 8'h65;  // 'e' bad header / channel out of range
  localparam logic [7:0] CODE_LEN = 8'h6C;  // 'l' zero length
  localparam logic [7:0] CODE_OK  = 8'h24;  // '$' channel completed
  localparam logic [7:0] CODE_TO  = 8'h74;  // 't' timeout

  state_t            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic [7:0]        rem_q, rem_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [NUM_CH-1:0] ch_sel_q, ch_sel_d;
  logic              ch_start_q, ch_start_d;
  logic [7:0]        ch_data_q, ch_data_d;
  logic              ch_valid_q, ch_valid_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_count_q, err_count_d;

  logic              in_take, ch_take, timed_out, status_go;
  logic [7:0]        code;
  logic [NUM_CH-1:0] sel_onehot;

  // Next-state and next-output logic for the packet FSM, timer and error counter.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rem_d       = rem_q;
    in_ready_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ch_sel_d    = ch_sel_q;
    ch_start_d  = 1'b0;
    ch_data_d   = ch_data_q;
    ch_valid_d  = ch_valid_q;
    err_count_d = err_count_q;
    status_go   = 1'b0;
    code        = CODE_OK;

    // in_ready is a registered one-cycle rd_en pulse, so a byte is taken the cycle it is high.
    in_take   = in_ready_q & bus.in_valid;
    ch_take   = ch_valid_q & bus.ch_ready;
    timed_out = (timer_q == TO_W'(TIMEOUT - 1));

    sel_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_onehot[i] = (ch_q == 4'(i));
    end

    case (state_q)
      S_IDLE: begin
        if (in_take) begin
          if (bus.in_data[7:4] == SYNC && {1'b0, bus.in_data[3:0]} < 5'(NUM_CH)) begin
            ch_d    = bus.in_data[3:0];
            state_d = S_LEN;
          end else begin
            status_go = 1'b1;
            code      = CODE_HDR;
          end
        end else begin
          in_ready_d = bus.in_valid & ~in_ready_q;
        end
      end

      S_LEN: begin
        if (timed_out) begin
          status_go = 1'b1;
          code      = CODE_TO;
        end else if (in_take) begin
          if (bus.in_data == 8'd0) begin
            status_go = 1'b1;
            code      = CODE_LEN;
          end else begin
            rem_d      = bus.in_data;
            ch_sel_d   = sel_onehot;
            ch_start_d = 1'b1;
            state_d    = S_PAY;
          end
        end else begin
          in_ready_d = bus.in_valid & ~in_ready_q;
        end
      end

      S_PAY: begin
        if (timed_out) begin
          status_go  = 1'b1;
          code       = CODE_TO;
          ch_valid_d = 1'b0;
        end else begin
          if (ch_take) ch_valid_d = 1'b0;
          if (in_take) begin
            ch_data_d  = bus.in_data;
            ch_valid_d = 1'b1;
            rem_d      = rem_q - 8'd1;
          end
          if (ch_take && rem_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            // Request only when the channel slot is guaranteed empty on the take cycle.
            in_ready_d = bus.in_valid & ~in_ready_q & (rem_q != 8'd0)
                         & (~ch_valid_q | bus.ch_ready);
          end
        end
      end

      S_DONE: begin
        if (timed_out) begin
          status_go = 1'b1;
          code      = CODE_TO;
        end else if (|(bus.ch_done & ch_sel_q)) begin
          status_go = 1'b1;
          code      = CODE_OK;
        end
      end

      S_STATUS: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          ch_sel_d    = '0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (status_go) begin
      state_d     = S_STATUS;
      out_valid_d = 1'b1;
      out_data_d  = code;
      if (code != CODE_OK && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    busy_d = (state_d != S_IDLE);

    if (state_d != state_q || in_take || ch_take) begin
      timer_d = '0;
    end else if (state_q == S_LEN || state_q == S_PAY || state_q == S_DONE) begin
      timer_d = timer_q + TO_W'(1);
    end else begin
      timer_d = '0;
    end
  end

  // All state and outputs registered; asynchronous clear to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      rem_q       <= '0;
      timer_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ch_sel_q    <= '0;
      ch_start_q  <= 1'b0;
      ch_data_q   <= '0;
      ch_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ch_sel_q    <= ch_sel_d;
      ch_start_q  <= ch_start_d;
      ch_data_q   <= ch_data_d;
      ch_valid_q  <= ch_valid_d;
      busy_q      <= busy_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ch_sel    = ch_sel_q;
  assign bus.ch_start  = ch_start_q;
  assign bus.ch_data   = ch_data_q;
  assign bus.ch_valid  = ch_valid_q;
  assign bus.busy      = busy_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_serial_cmd_router.sv
// Directed bench for serial_cmd_router: FIFO source, channel sink and status sink models.
module tb_serial_cmd_router;

  localparam int NUM_CH  = 8;
  localparam int TIMEOUT = 40;
  localparam int TO_W    = 8;

  logic clk;
  logic rst_n;

  serial_cmd_router_if #(.NUM_CH(NUM_CH)) bus ();

  serial_cmd_router #(
    .NUM_CH (NUM_CH),
    .SYNC   (4'hF),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] src_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] st_q[$];
  logic       src_en = 1'b1;
  int         rdy_mode = 0;   // 0: ch_ready high, 1: toggle, 2: low
  logic       or_en = 1'b1;

  int   cyc = 0;
  int   last_take_cyc = 0;
  int   ov_rise_cyc = 0;
  int   start_cnt = 0;
  int   sel_cnt = 0;
  logic [NUM_CH-1:0] sel_at_start = '0;
  logic [NUM_CH-1:0] sel_before_start = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source, sink and monitor models, all stepped on the falling edge.
  initial begin
    logic       in_pend = 1'b0, ch_pend = 1'b0, st_pend = 1'b0, ov_prev = 1'b0;
    logic [7:0] ch_cap = '0, st_cap = '0;
    logic [NUM_CH-1:0] sel_prev = '0;
    int         pend_cyc = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ch_ready  = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (in_pend && src_q.size() > 0) begin
        void'(src_q.pop_front());
        last_take_cyc = pend_cyc;
      end
      if (ch_pend) rx_q.push_back(ch_cap);
      if (st_pend) st_q.push_back(st_cap);
      if (bus.ch_start) begin
        start_cnt++;
        sel_at_start     = bus.ch_sel;
        sel_before_start = sel_prev;
      end
      if (bus.ch_sel != '0) sel_cnt++;
      sel_prev = bus.ch_sel;
      if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
      ov_prev = bus.out_valid;

      bus.in_valid = src_en && (src_q.size() > 0);
      bus.in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      case (rdy_mode)
        0:       bus.ch_ready = 1'b1;
        1:       bus.ch_ready = ~bus.ch_ready;
        default: bus.ch_ready = 1'b0;
      endcase
      bus.out_ready = or_en;

      in_pend  = bus.in_valid && bus.in_ready;
      pend_cyc = cyc;
      ch_pend  = bus.ch_valid && bus.ch_ready;
      ch_cap   = bus.ch_data;
      st_pend  = bus.out_valid && bus.out_ready;
      st_cap   = bus.out_data;
    end
  end

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) src_q.push_back(b[i]);
  endtask

  task automatic wait_status(input string tag, input logic [7:0] exp);
    int n = 0;
    while (st_q.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (st_q.size() == 0) begin
      check_eq({tag, "_timeout"}, st_q.size(), 1);
    end else begin
      check_eq(tag, st_q.pop_front(), exp);
    end
  endtask

  task automatic wait_rx(input string tag, input int cnt);
    int n = 0;
    while (rx_q.size() < cnt && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rx_count"}, rx_q.size(), cnt);
  endtask

  task automatic pulse_done(input logic [NUM_CH-1:0] v);
    @(negedge clk);
    bus.ch_done = v;
    @(negedge clk);
    bus.ch_done = '0;
  endtask

  initial begin
    int starts0, sel0, bad;
    bus.ch_done = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_ch_sel", bus.ch_sel, 0);
    check_eq("rst_err", bus.err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: valid packet to channel 2
    push_bytes('{8'hF2, 8'h03, 8'hAA, 8'hBB, 8'hCC});
    wait_rx("t1", 3);
    repeat (3) @(negedge clk);
    check_eq("t1_sel_done", bus.ch_sel, 8'h04);
    pulse_done(8'h20);                      // other channel: ignored
    check_eq("t1_other_done_busy", bus.busy, 1);
    check_eq("t1_other_done_ov", bus.out_valid, 0);
    pulse_done(8'h04);
    wait_status("t1_status", 8'h24);
    check_eq("t1_b0", rx_q[0], 8'hAA);
    check_eq("t1_b1", rx_q[1], 8'hBB);
    check_eq("t1_b2", rx_q[2], 8'hCC);
    check_eq("t1_starts", start_cnt, 1);
    check_eq("t1_sel_at_start", sel_at_start, 8'h04);
    check_eq("t1_sel_before_start", sel_before_start, 8'h00);
    repeat (2) @(negedge clk);
    check_eq("t1_sel_idle", bus.ch_sel, 0);
    check_eq("t1_err", bus.err_count, 0);
    rx_q.delete();

    // 2: bad header then packet to channel 0
    push_bytes('{8'h5A, 8'hF0, 8'h01, 8'h11});
    wait_status("t2_status_hdr", 8'h65);
    wait_rx("t2", 1);
    pulse_done(8'h01);
    wait_status("t2_status_ok", 8'h24);
    check_eq("t2_b0", rx_q[0], 8'h11);
    check_eq("t2_err", bus.err_count, 1);
    rx_q.delete();

    // 3: channel 9 out of range; 01 and 00 each re-parsed as bad headers
    starts0 = start_cnt;
    sel0    = sel_cnt;
    push_bytes('{8'hF9, 8'h01, 8'h00});
    wait_status("t3_status_a", 8'h65);
    wait_status("t3_status_b", 8'h65);
    wait_status("t3_status_c", 8'h65);
    check_eq("t3_sel_cycles", sel_cnt - sel0, 0);
    check_eq("t3_starts", start_cnt - starts0, 0);
    check_eq("t3_err", bus.err_count, 4);

    // 4: zero length
    starts0 = start_cnt;
    push_bytes('{8'hF1, 8'h00});
    wait_status("t4_status", 8'h6C);
    check_eq("t4_starts", start_cnt - starts0, 0);
    check_eq("t4_err", bus.err_count, 5);

    // 5: payload stalls; channel holding back, input runs dry
    rdy_mode = 2;
    push_bytes('{8'hF3, 8'h02, 8'hAA});
    wait_status("t5_status", 8'h74);
    // ov_rise is sampled one falling edge after the edge that raised out_valid
    check_eq("t5_to_latency", ov_rise_cyc - last_take_cyc, TIMEOUT + 1);
    check_eq("t5_ch_valid", bus.ch_valid, 0);
    check_eq("t5_err", bus.err_count, 6);
    rx_q.delete();

    // 6: toggling ch_ready, status held off for 10 cycles
    rdy_mode = 1;
    or_en    = 1'b0;
    push_bytes('{8'hF4, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    wait_rx("t6", 6);
    pulse_done(8'h10);
    begin
      int n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.out_valid === 1'b1 && bus.out_data === 8'h24)) bad++;
      @(negedge clk);
    end
    check_eq("t6_hold_unstable_cycles", bad, 0);
    check_eq("t6_no_early_status", st_q.size(), 0);
    or_en = 1'b1;
    wait_status("t6_status", 8'h24);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t6_b%0d", i), rx_q[i], 32'(i + 1));
    check_eq("t6_err", bus.err_count, 6);
    rx_q.delete();

    // 7: asynchronous reset in the middle of the payload
    rdy_mode = 2;
    push_bytes('{8'hF5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40});
    begin
      int n = 0;
      while (!bus.ch_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("t7_reached_pay", bus.ch_valid, 1);
    end
    check_eq("t7_sel_pay", bus.ch_sel, 8'h20);
    #2 rst_n = 1'b0;
    src_en = 1'b0;
    #1;
    check_eq("t7_busy", bus.busy, 0);
    check_eq("t7_ch_sel", bus.ch_sel, 0);
    check_eq("t7_ch_valid", bus.ch_valid, 0);
    check_eq("t7_ch_data", bus.ch_data, 0);
    check_eq("t7_out_data", bus.out_data, 0);
    check_eq("t7_err", bus.err_count, 0);
    check_eq("t7_in_ready", bus.in_ready, 0);
    src_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    src_en = 1'b1;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check_eq("t7_idle_after", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
